// File: rtl/gyro_axil_slave.sv
// AXI4-Lite slave: four RW control registers, latched gyro X/Y/Z samples and a
// status word holding a new-data flag and a wrapping sample counter.
module gyro_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [15:0]                     gyro_x,
    input  logic [15:0]                     gyro_y,
    input  logic [15:0]                     gyro_z,
    input  logic                            gyro_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg0_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg1_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg2_reg
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    // up_q keeps the ready outputs low until the first edge after reset
    logic          up_q;
    logic          aw_held_q;
    logic [2:0]    aw_idx_q;
    logic          w_held_q;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;
    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rw_q [4];
    logic [15:0]   x_q, y_q, z_q, count_q;
    logic          new_data_q;

    logic          aw_hs, w_hs, ar_hs, r_hs, commit;
    logic [2:0]    ar_idx;
    logic [DW-1:0] rd_mux;
    logic          unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = up_q & ~aw_held_q;
    assign s00_axi_wready  = up_q & ~w_held_q;
    assign s00_axi_arready = up_q & ~rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign r_hs   = rvalid_q & s00_axi_rready;
    assign commit = aw_held_q & w_held_q & ~bvalid_q;
    assign ar_idx = s00_axi_araddr[4:2];

    assign ctrl_reg = rw_q[0];
    assign cfg0_reg = rw_q[1];
    assign cfg1_reg = rw_q[2];
    assign cfg2_reg = rw_q[3];

    // Read data selection from current (pre-update) register contents
    always_comb begin
        rd_mux = '0;
        case (ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = rw_q[ar_idx[1:0]];
            3'd4: rd_mux = {{(DW-16){x_q[15]}}, x_q};
            3'd5: rd_mux = {{(DW-16){y_q[15]}}, y_q};
            3'd6: rd_mux = {{(DW-16){z_q[15]}}, z_q};
            default: begin
                rd_mux[0]     = new_data_q;
                rd_mux[31:16] = count_q;
            end
        endcase
    end

    // Write-channel holders and response state
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            up_q      <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            up_q <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= s00_axi_awaddr[4:2];
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end else if (commit) begin
                w_held_q <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // RW register file with byte-lane strobes; writes to RO addresses are dropped
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                rw_q[i] <= '0;
            end
        end else if (commit && !aw_idx_q[2]) begin
            for (int b = 0; b < NB; b++) begin
                if (w_strb_q[b]) begin
                    rw_q[aw_idx_q[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Read channel: capture data on address handshake, hold until accepted
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    // Sensor shadows, sample counter and new-data flag (a new sample beats the clear)
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            count_q    <= '0;
            new_data_q <= 1'b0;
        end else begin
            if (gyro_valid) begin
                x_q        <= gyro_x;
                y_q        <= gyro_y;
                z_q        <= gyro_z;
                count_q    <= count_q + 16'd1;
                new_data_q <= 1'b1;
            end else if (ar_hs && ar_idx == 3'd7) begin
                new_data_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gyro_axil_slave.sv
// Directed self-checking bench for gyro_axil_slave.
module tb_gyro_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        gyro_valid;
    logic [31:0] ctrl_reg, cfg0_reg, cfg1_reg, cfg2_reg;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    gyro_axil_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .gyro_x         (gyro_x),
        .gyro_y         (gyro_y),
        .gyro_z         (gyro_z),
        .gyro_valid     (gyro_valid),
        .ctrl_reg       (ctrl_reg),
        .cfg0_reg       (cfg0_reg),
        .cfg1_reg       (cfg1_reg),
        .cfg2_reg       (cfg2_reg)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit aw_done, w_done, b_done, hs_aw, hs_w;
        aw_done = 0; w_done = 0; b_done = 0;
        @(negedge clk);
        awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            hs_aw = awvalid & awready;
            hs_w  = wvalid & wready;
            @(posedge clk); #1;
            if (hs_aw) begin awvalid = 0; aw_done = 1; end
            if (hs_w)  begin wvalid = 0;  w_done = 1;  end
            @(negedge clk);
        end
        for (int i = 0; i < 20 && !b_done; i++) begin
            if (bvalid) begin
                check_eq("bresp", bresp, 0);
                b_done = 1;
                @(posedge clk); #1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("wr_done", {29'b0, aw_done, w_done, b_done}, 32'h7);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        bit a_done, r_done;
        a_done = 0; r_done = 0; data = '0;
        @(negedge clk);
        araddr = addr; arvalid = 1;
        for (int i = 0; i < 20 && !a_done; i++) begin
            if (arready) begin
                a_done = 1;
                @(posedge clk); #1;
                arvalid = 0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        for (int i = 0; i < 20 && !r_done; i++) begin
            if (rvalid) begin
                data = rdata;
                check_eq("rresp", rresp, 0);
                r_done = 1;
                @(posedge clk); #1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("rd_done", {30'b0, a_done, r_done}, 32'h3);
    endtask

    task automatic gyro_pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        gyro_x = x; gyro_y = y; gyro_z = z; gyro_valid = 1;
        @(posedge clk); #1;
        gyro_valid = 0;
    endtask

    initial begin
        rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; wdata = 0; wstrb = 0;
        bready = 1; rready = 1; gyro_x = 0; gyro_y = 0; gyro_z = 0; gyro_valid = 0;

        // Reset state and ready release
        repeat (3) @(negedge clk);
        check_eq("rst_awready", awready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_ctrl", ctrl_reg, 0);
        rst = 0;
        #1 check_eq("rel_wready_pre", wready, 0);
        @(negedge clk);
        check_eq("rel_awready", awready, 1);
        check_eq("rel_wready", wready, 1);
        check_eq("rel_arready", arready, 1);

        // Basic write/read-back of all RW registers
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h00, rd); check_eq("rd_00", rd, 32'h1);
        axi_read(5'h04, rd); check_eq("rd_04", rd, 32'h2);
        axi_read(5'h08, rd); check_eq("rd_08", rd, 32'h3);
        axi_read(5'h0C, rd); check_eq("rd_0c", rd, 32'h4);
        check_eq("ctrl_reg", ctrl_reg, 32'h1);
        check_eq("cfg2_reg", cfg2_reg, 32'h4);

        // W leads AW by three cycles, response back-pressured for five cycles
        @(negedge clk);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1; bready = 0;
        check_eq("w_first_rdy", wready, 1);
        @(posedge clk); #1 wvalid = 0;
        @(negedge clk);
        check_eq("wready_held", wready, 0);
        check_eq("awready_idle", awready, 1);
        @(negedge clk);
        check_eq("wready_held2", wready, 0);
        @(negedge clk);
        awaddr = 5'h04; awvalid = 1;
        @(posedge clk); #1 awvalid = 0;
        @(negedge clk);
        check_eq("bvalid_pre", bvalid, 0);
        check_eq("awready_held", awready, 0);
        check_eq("wready_both", wready, 0);
        @(negedge clk);
        check_eq("cfg0_commit", cfg0_reg, 32'h55);
        for (int i = 0; i < 5; i++) begin
            check_eq("bvalid_hold", bvalid, 1);
            @(negedge clk);
        end
        bready = 1;
        check_eq("bvalid_last", bvalid, 1);
        @(negedge clk);
        check_eq("bvalid_drop", bvalid, 0);
        @(negedge clk);
        check_eq("bvalid_single", bvalid, 0);

        // Read coincident with commit to the same register returns the old value
        @(negedge clk);
        awaddr = 5'h08; awvalid = 1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        @(negedge clk);
        araddr = 5'h08; arvalid = 1;
        @(posedge clk); #1 arvalid = 0;
        @(negedge clk);
        check_eq("rw_race_rvalid", rvalid, 1);
        check_eq("rw_race_old", rdata, 32'h3);
        check_eq("rw_race_bvalid", bvalid, 1);
        check_eq("rw_race_cfg1", cfg1_reg, 32'h77);
        @(posedge clk); #1;

        // Byte-lane strobes
        axi_write(5'h00, 32'hAABBCCDD, 4'hF);
        axi_write(5'h00, 32'h11223344, 4'h5);
        axi_read(5'h00, rd); check_eq("strb_merge", rd, 32'hAA22CC44);

        // Sensor sample capture and status
        gyro_pulse(16'h8001, 16'h1234, 16'hFFFE);
        axi_read(5'h10, rd); check_eq("gyro_x", rd, 32'hFFFF8001);
        axi_read(5'h14, rd); check_eq("gyro_y", rd, 32'h00001234);
        axi_read(5'h18, rd); check_eq("gyro_z", rd, 32'hFFFFFFFE);
        axi_read(5'h1C, rd); check_eq("status1", rd, 32'h00010001);
        axi_read(5'h1C, rd); check_eq("status2", rd, 32'h00010000);
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF);
        axi_read(5'h10, rd); check_eq("ro_x_kept", rd, 32'hFFFF8001);
        check_eq("ro_no_alias", ctrl_reg, 32'hAA22CC44);

        // Status read coincident with a new sample: flag survives
        gyro_pulse(16'h0001, 16'h0002, 16'h0003);
        @(negedge clk);
        araddr = 5'h1C; arvalid = 1; gyro_valid = 1;
        check_eq("race_arready", arready, 1);
        @(posedge clk); #1 arvalid = 0; gyro_valid = 0;
        @(negedge clk);
        check_eq("race_rvalid", rvalid, 1);
        check_eq("race_status", rdata, 32'h00020001);
        @(posedge clk); #1;
        axi_read(5'h1C, rd); check_eq("race_kept", rd, 32'h00030001);

        // Counter wrap: 3 + 65532 = 0xFFFF, one more wraps to 0
        @(negedge clk);
        gyro_valid = 1;
        repeat (65532) @(posedge clk);
        #1 gyro_valid = 0;
        axi_read(5'h1C, rd); check_eq("count_ffff", rd, 32'hFFFF0001);
        gyro_pulse(16'h0, 16'h0, 16'h0);
        axi_read(5'h1C, rd); check_eq("count_wrap", rd, 32'h00000001);

        // Reset with AW held and a read response pending
        @(negedge clk);
        rready = 0; awaddr = 5'h00; awvalid = 1; araddr = 5'h00; arvalid = 1;
        @(posedge clk); #1 awvalid = 0; arvalid = 0;
        @(negedge clk);
        check_eq("pre_rst_rvalid", rvalid, 1);
        rst = 1;
        #1;
        check_eq("mid_rst_awready", awready, 0);
        check_eq("mid_rst_wready", wready, 0);
        check_eq("mid_rst_arready", arready, 0);
        check_eq("mid_rst_bvalid", bvalid, 0);
        check_eq("mid_rst_rvalid", rvalid, 0);
        check_eq("mid_rst_rdata", rdata, 0);
        check_eq("mid_rst_ctrl", ctrl_reg, 0);
        check_eq("mid_rst_cfg1", cfg1_reg, 0);
        repeat (2) @(negedge clk);
        rst = 0; rready = 1;
        @(negedge clk);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1 wvalid = 0;
        repeat (3) @(negedge clk);
        check_eq("no_stale_commit", bvalid, 0);
        axi_read(5'h00, rd); check_eq("post_rst_00", rd, 0);
        axi_read(5'h1C, rd); check_eq("post_rst_status", rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
